// File: rtl/clk_ratio_meter.sv
// Measures period and high time of a slow divided clock in system-clock cycles,
// with lock and timeout tracking. Define CLK_RATIO_METER_SYNC_EN to add a two-flop synchronizer on I_SIG.
module clk_ratio_meter #(
  parameter int CNT_W        = 16,
  parameter int LOCK_MATCHES = 2
) (
  input  logic             I_CLK,
  input  logic             rst,
  input  logic             I_SIG,
  output logic [CNT_W-1:0] O_PERIOD,
  output logic [CNT_W-1:0] O_HIGH,
  output logic             O_VALID,
  output logic             O_LOCKED,
  output logic             O_ERR
);

`ifdef CLK_RATIO_METER_SYNC_EN
  localparam int STAGES = 3;
`else
  localparam int STAGES = 1;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [3:0]       LOCK_N  = 4'(LOCK_MATCHES);

  typedef enum logic {IDLE, RUN} state_t;

  // Sampler chain; each stage carries a valid bit so stale reset zeros never look like an edge.
  logic [STAGES-1:0] smp_q, smp_d;
  logic [STAGES-1:0] smp_vld_q, smp_vld_d;
  logic              s_prev_q, s_prev_d;
  logic              prev_vld_q, prev_vld_d;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0]  high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0]  cap_period_q, cap_period_d;
  logic [CNT_W-1:0]  cap_high_q, cap_high_d;
  logic [3:0]        match_q, match_d;
  logic              pub_q, pub_d;
  logic              tmo_q, tmo_d;

  logic [CNT_W-1:0]  period_out_q, period_out_d;
  logic [CNT_W-1:0]  high_out_q, high_out_d;
  logic              valid_out_q, valid_out_d;
  logic              locked_out_q, locked_out_d;
  logic              err_out_q, err_out_d;

  logic s;
  logic s_vld;
  logic rise;

  assign s     = smp_q[STAGES-1];
  assign s_vld = smp_vld_q[STAGES-1];
  assign rise  = prev_vld_q & s & ~s_prev_q;

  always_comb begin
    smp_d        = smp_q;
    smp_vld_d    = smp_vld_q;
    smp_d[0]     = I_SIG;
    smp_vld_d[0] = 1'b1;
    for (int i = 1; i < STAGES; i++) begin
      smp_d[i]     = smp_q[i-1];
      smp_vld_d[i] = smp_vld_q[i-1];
    end
    s_prev_d   = s;
    prev_vld_d = s_vld;
  end

  always_comb begin
    state_d      = state_q;
    per_cnt_d    = per_cnt_q;
    high_cnt_d   = high_cnt_q;
    cap_period_d = cap_period_q;
    cap_high_d   = cap_high_q;
    match_d      = match_q;
    pub_d        = 1'b0;
    tmo_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (rise) begin
          per_cnt_d  = CNT_W'(1);
          high_cnt_d = CNT_W'(1);
          state_d    = RUN;
        end
      end
      RUN: begin
        if (rise) begin
          cap_period_d = per_cnt_q;
          cap_high_d   = high_cnt_q;
          pub_d        = 1'b1;
          // cap_period_q still holds the previously published period here.
          if (per_cnt_q == cap_period_q) begin
            match_d = (match_q >= LOCK_N) ? LOCK_N : 4'(match_q + 4'd1);
          end else begin
            match_d = 4'd1;
          end
          per_cnt_d  = CNT_W'(1);
          high_cnt_d = CNT_W'(1);
        end else if (per_cnt_q == CNT_MAX) begin
          tmo_d   = 1'b1;
          match_d = 4'd0;
          state_d = IDLE;
        end else begin
          per_cnt_d = per_cnt_q + CNT_W'(1);
          if (s && (high_cnt_q != CNT_MAX)) begin
            high_cnt_d = high_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    period_out_d = period_out_q;
    high_out_d   = high_out_q;
    locked_out_d = locked_out_q;
    err_out_d    = err_out_q;
    valid_out_d  = pub_q;
    if (pub_q) begin
      period_out_d = cap_period_q;
      high_out_d   = cap_high_q;
      locked_out_d = (match_q >= LOCK_N);
    end
    if (tmo_q) begin
      err_out_d    = 1'b1;
      locked_out_d = 1'b0;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (!rst) begin
      smp_q        <= '0;
      smp_vld_q    <= '0;
      s_prev_q     <= 1'b0;
      prev_vld_q   <= 1'b0;
      state_q      <= IDLE;
      per_cnt_q    <= '0;
      high_cnt_q   <= '0;
      cap_period_q <= '0;
      cap_high_q   <= '0;
      match_q      <= '0;
      pub_q        <= 1'b0;
      tmo_q        <= 1'b0;
      period_out_q <= '0;
      high_out_q   <= '0;
      valid_out_q  <= 1'b0;
      locked_out_q <= 1'b0;
      err_out_q    <= 1'b0;
    end else begin
      smp_q        <= smp_d;
      smp_vld_q    <= smp_vld_d;
      s_prev_q     <= s_prev_d;
      prev_vld_q   <= prev_vld_d;
      state_q      <= state_d;
      per_cnt_q    <= per_cnt_d;
      high_cnt_q   <= high_cnt_d;
      cap_period_q <= cap_period_d;
      cap_high_q   <= cap_high_d;
      match_q      <= match_d;
      pub_q        <= pub_d;
      tmo_q        <= tmo_d;
      period_out_q <= period_out_d;
      high_out_q   <= high_out_d;
      valid_out_q  <= valid_out_d;
      locked_out_q <= locked_out_d;
      err_out_q    <= err_out_d;
    end
  end

  assign O_PERIOD = period_out_q;
  assign O_HIGH   = high_out_q;
  assign O_VALID  = valid_out_q;
  assign O_LOCKED = locked_out_q;
  assign O_ERR    = err_out_q;

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Bench for clk_ratio_meter: directed and random divided-clock waveforms checked every cycle
// against an edge-timing reference model. Honours CLK_RATIO_METER_SYNC_EN for latency.
module tb_clk_ratio_meter;

  localparam int CW   = 6;
  localparam int LM   = 2;
  localparam int MAXC = (1 << CW) - 1;
`ifdef CLK_RATIO_METER_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic          I_CLK = 1'b0;
  logic          rst;
  logic          I_SIG;
  logic [CW-1:0] O_PERIOD;
  logic [CW-1:0] O_HIGH;
  logic          O_VALID;
  logic          O_LOCKED;
  logic          O_ERR;

  clk_ratio_meter #(.CNT_W(CW), .LOCK_MATCHES(LM)) dut (
    .I_CLK(I_CLK), .rst(rst), .I_SIG(I_SIG),
    .O_PERIOD(O_PERIOD), .O_HIGH(O_HIGH), .O_VALID(O_VALID),
    .O_LOCKED(O_LOCKED), .O_ERR(O_ERR)
  );

  always #5 I_CLK = ~I_CLK;

  typedef struct {
    int cyc;
    bit tmo;
    int p;
    int h;
    bit l;
  } ev_t;

  ev_t evq[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  // Reference model state, in terms of the I_SIG value seen at each clock edge.
  bit  have_prev, prev_v, armed;
  int  last_rise, hcnt, prev_pub, match;
  logic [CW-1:0] exp_period, exp_high;
  logic          exp_valid, exp_locked, exp_err;

  task automatic model_reset();
    evq.delete();
    have_prev = 0; prev_v = 0; armed = 0;
    last_rise = 0; hcnt = 0; prev_pub = 0; match = 0;
    exp_period = '0; exp_high = '0;
    exp_valid = 0; exp_locked = 0; exp_err = 0;
  endtask

  task automatic model_sample(input bit v);
    bit  r;
    ev_t e;
    if (!have_prev) begin
      have_prev = 1; prev_v = v;
      return;
    end
    r = v && !prev_v;
    prev_v = v;
    if (armed) begin
      if (r) begin
        e.cyc = cyc + LAT; e.tmo = 0;
        e.p = cyc - last_rise; e.h = hcnt;
        match = (e.p == prev_pub) ? ((match + 1 > LM) ? LM : match + 1) : 1;
        prev_pub = e.p;
        e.l = (match >= LM);
        evq.push_back(e);
        last_rise = cyc; hcnt = 1;
      end else if (cyc - last_rise == MAXC) begin
        e.cyc = cyc + LAT; e.tmo = 1; e.p = 0; e.h = 0; e.l = 0;
        evq.push_back(e);
        armed = 0; match = 0;
      end else if (v) begin
        hcnt++;
      end
    end else if (r) begin
      armed = 1; last_rise = cyc; hcnt = 1;
    end
  endtask

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cycle %0d observed %0d expected %0d", tag, cyc, obs, expv);
    end
  endtask

  task automatic tick(input logic sig_nx, input logic rst_nx);
    ev_t e;
    @(posedge I_CLK);
    cyc++;
    if (!rst) model_reset();
    else model_sample(I_SIG);
    exp_valid = 0;
    while (evq.size() > 0 && evq[0].cyc == cyc) begin
      e = evq.pop_front();
      if (e.tmo) begin
        exp_err = 1; exp_locked = 0;
      end else begin
        exp_period = CW'(e.p); exp_high = CW'(e.h);
        exp_locked = e.l; exp_valid = 1;
      end
    end
    #1;
    check("valid",  int'(O_VALID),  int'(exp_valid));
    check("period", int'(O_PERIOD), int'(exp_period));
    check("high",   int'(O_HIGH),   int'(exp_high));
    check("locked", int'(O_LOCKED), int'(exp_locked));
    check("err",    int'(O_ERR),    int'(exp_err));
    if (exp_valid)
      $display("cycle %0d strobe period=%0d high=%0d locked=%0d err=%0d",
               cyc, O_PERIOD, O_HIGH, O_LOCKED, O_ERR);
    I_SIG = sig_nx;
    rst   = rst_nx;
  endtask

  task automatic wave(input int h, input int l);
    for (int i = 0; i < h; i++) tick(1'b1, 1'b1);
    for (int i = 0; i < l; i++) tick(1'b0, 1'b1);
  endtask

  task automatic hold(input logic lvl, input int n, input logic rst_lvl);
    for (int i = 0; i < n; i++) tick(lvl, rst_lvl);
  endtask

  initial begin
    int n, h, reps;
    I_SIG = 0;
    rst   = 0;
    model_reset();

    // Reset, then constant low: stays idle, no timeout.
    hold(1'b0, 3, 1'b0);
    hold(1'b0, 100, 1'b1);

    // /10 at 50% duty, then 3/7 duty, then ratio change to /8.
    repeat (6) wave(5, 5);
    repeat (3) wave(3, 7);
    repeat (3) wave(4, 4);

    // Reset mid-high while locked, then I_SIG held high: no edge, no timeout.
    repeat (3) wave(5, 5);
    hold(1'b1, 2, 1'b1);
    hold(1'b1, 1, 1'b0);
    hold(1'b1, 100, 1'b1);
    hold(1'b0, 5, 1'b1);
    repeat (3) wave(5, 5);

    // Longest countable period, then one cycle longer which times out.
    repeat (2) wave(1, 62);
    repeat (2) wave(5, 5);
    wave(1, 63);
    repeat (3) wave(5, 5);

    // One rise then I_SIG held low long past the counter range.
    wave(1, 80);
    repeat (3) wave(5, 5);

    // Reset clears the sticky error.
    hold(1'b0, 1, 1'b0);
    hold(1'b0, 5, 1'b1);

    // Random ratios and duty cycles, each repeated a few times to exercise lock.
    for (int k = 0; k < 25; k++) begin
      n    = $urandom_range(40, 2);
      h    = $urandom_range(n - 1, 1);
      reps = $urandom_range(3, 1);
      for (int j = 0; j < reps; j++) wave(h, n - h);
    end
    hold(1'b0, 10, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
